// File: rtl/vend_pkg.sv
// Shared types and constants for the vend dispense controller.
package vend_pkg;

    localparam int unsigned CHANGE_W           = 3;
    localparam int unsigned MAX_CHANGE_NICKELS = 4;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_SODA_TO = 2'b01;
    localparam logic [1:0] FLT_HOP_TO  = 2'b10;
    localparam logic [1:0] FLT_BAD_JOB = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_POP        = 3'd1,
        ST_SODA_PULSE = 3'd2,
        ST_SODA_WAIT  = 3'd3,
        ST_COIN_PULSE = 3'd4,
        ST_COIN_WAIT  = 3'd5,
        ST_FAULT      = 3'd6
    } dispense_state_e;

    typedef struct packed {
        logic                soda;
        logic [CHANGE_W-1:0] change;
    } vend_job_t;

    // True when a job asks for more nickels than one vend may ever return.
    function automatic logic change_out_of_range(input logic [CHANGE_W-1:0] change);
        return change > CHANGE_W'(MAX_CHANGE_NICKELS);
    endfunction

endpackage

// File: rtl/vend_job_fifo.sv
// Synchronous FIFO of vend jobs with registered full/empty flags.
module vend_job_fifo
    import vend_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  vend_job_t        wdata,
    input  logic             pop,
    output vend_job_t        head_c,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    vend_job_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign head_c  = mem_q[rd_ptr_q];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers, occupancy and flags, all updated from the next occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vend job sequencer: queues jobs, pulses the soda motor and the nickel
// hopper one coin at a time, waits for sensor acks and tracks inventory.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned INV_W          = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic             job_soda_i,
    input  logic [2:0]       job_change_i,
    output logic             soda_motor_o,
    input  logic             soda_done_i,
    output logic             hopper_kick_o,
    input  logic             hopper_coin_i,
    input  logic             refill_valid_i,
    input  logic [INV_W-1:0] refill_nickels_i,
    input  logic             fault_clear_i,
    output logic [INV_W-1:0] nickel_count_o,
    output logic             low_change_o,
    output logic             busy_o,
    output logic             fault_o,
    output logic [1:0]       fault_code_o
);

    localparam int unsigned QCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TMR_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned SUM_W   = INV_W + 1;

    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUM_W-1:0] INV_SAT      = SUM_W'((2 ** INV_W) - 1);
    localparam logic [INV_W-1:0] LOW_THRESH   = INV_W'(MAX_CHANGE_NICKELS);

    dispense_state_e     state_q;
    dispense_state_e     state_d;
    logic [TMR_W-1:0]    tmr_q;
    logic [TMR_W-1:0]    tmr_d;
    logic [CHANGE_W-1:0] remaining_q;
    logic [CHANGE_W-1:0] remaining_d;
    logic [1:0]          fault_code_q;
    logic [1:0]          fault_code_d;
    logic [INV_W-1:0]    inv_q;
    logic [INV_W-1:0]    inv_d;
    logic [SUM_W-1:0]    inv_sum;
    logic                inv_dec;

    vend_job_t           wr_job;
    vend_job_t           head;
    logic                push;
    logic                pop;
    logic                q_full;
    logic                q_empty;
    logic [QCNT_W-1:0]   q_count;
    logic [QCNT_W-1:0]   q_count_d;
    logic                timed_state;

    assign wr_job         = '{soda: job_soda_i, change: job_change_i};
    assign push           = job_valid_i && !q_full;
    assign q_count_d      = q_count + QCNT_W'(push) - QCNT_W'(pop);
    assign nickel_count_o = inv_q;
    assign fault_code_o   = fault_code_q;

    vend_job_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_job_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (push),
        .wdata  (wr_job),
        .pop    (pop),
        .head_c (head),
        .full   (q_full),
        .empty  (q_empty),
        .count  (q_count)
    );

    // Next-state, job latch, fault code and coin-count decisions.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        fault_code_d = fault_code_q;
        inv_dec      = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A job being written this cycle counts, so POP follows acceptance directly.
                if (!q_empty || push) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                pop = 1'b1;
                if (change_out_of_range(head.change) || (INV_W'(head.change) > inv_q)) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_BAD_JOB;
                    remaining_d  = '0;
                end else if (head.soda) begin
                    state_d     = ST_SODA_PULSE;
                    remaining_d = head.change;
                end else if (head.change != '0) begin
                    state_d     = ST_COIN_PULSE;
                    remaining_d = head.change;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SODA_PULSE: begin
                if (tmr_q == PULSE_LAST) begin
                    state_d = ST_SODA_WAIT;
                end
            end
            ST_SODA_WAIT: begin
                if (soda_done_i) begin
                    state_d = (remaining_q != '0) ? ST_COIN_PULSE : ST_IDLE;
                end else if (tmr_q == TIMEOUT_LAST) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_SODA_TO;
                    remaining_d  = '0;
                end
            end
            ST_COIN_PULSE: begin
                if (tmr_q == PULSE_LAST) begin
                    state_d = ST_COIN_WAIT;
                end
            end
            ST_COIN_WAIT: begin
                if (hopper_coin_i) begin
                    inv_dec     = 1'b1;
                    remaining_d = remaining_q - CHANGE_W'(1);
                    state_d     = (remaining_q != CHANGE_W'(1)) ? ST_COIN_PULSE : ST_IDLE;
                end else if (tmr_q == TIMEOUT_LAST) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FLT_HOP_TO;
                    remaining_d  = '0;
                end
            end
            ST_FAULT: begin
                if (fault_clear_i) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FLT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pulse/timeout timer: restarts on every state entry, counts only in timed states.
    always_comb begin
        timed_state = (state_q == ST_SODA_PULSE) || (state_q == ST_SODA_WAIT) ||
                      (state_q == ST_COIN_PULSE) || (state_q == ST_COIN_WAIT);
        tmr_d = '0;
        if (timed_state && (state_d == state_q)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    // Inventory: refill and coin-out both apply, clamped to the counter range.
    always_comb begin
        inv_sum = {1'b0, inv_q};
        if (refill_valid_i) begin
            inv_sum = inv_sum + {1'b0, refill_nickels_i};
        end
        if (inv_dec && (inv_sum != '0)) begin
            inv_sum = inv_sum - SUM_W'(1);
        end
        inv_d = (inv_sum > INV_SAT) ? INV_SAT[INV_W-1:0] : inv_sum[INV_W-1:0];
    end

    // State, counters and all registered outputs, decoded from next-state values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            remaining_q   <= '0;
            fault_code_q  <= FLT_NONE;
            inv_q         <= '0;
            soda_motor_o  <= 1'b0;
            hopper_kick_o <= 1'b0;
            job_ready_o   <= 1'b1;
            low_change_o  <= 1'b1;
            busy_o        <= 1'b0;
            fault_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            remaining_q   <= remaining_d;
            fault_code_q  <= fault_code_d;
            inv_q         <= inv_d;
            soda_motor_o  <= (state_d == ST_SODA_PULSE);
            hopper_kick_o <= (state_d == ST_COIN_PULSE);
            job_ready_o   <= (q_count_d != QCNT_W'(FIFO_DEPTH));
            low_change_o  <= (inv_d < LOW_THRESH);
            busy_o        <= (state_d != ST_IDLE) || (q_count_d != '0);
            fault_o       <= (state_d == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: a per-cycle vector table for a full
// soda+change vend, then hand-written sequences for the multi-cycle corners.
module tb_vend_dispense_ctrl;

    localparam int PULSE   = 4;
    localparam int TIMEOUT = 1000;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       job_valid_i = 1'b0;
    logic       job_ready_o;
    logic       job_soda_i = 1'b0;
    logic [2:0] job_change_i = 3'd0;
    logic       soda_motor_o;
    logic       soda_done_i = 1'b0;
    logic       hopper_kick_o;
    logic       hopper_coin_i = 1'b0;
    logic       refill_valid_i = 1'b0;
    logic [5:0] refill_nickels_i = 6'd0;
    logic       fault_clear_i = 1'b0;
    logic [5:0] nickel_count_o;
    logic       low_change_o;
    logic       busy_o;
    logic       fault_o;
    logic [1:0] fault_code_o;

    vend_dispense_ctrl #(
        .FIFO_DEPTH     (4),
        .PULSE_CYCLES   (PULSE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .INV_W          (6)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .job_valid_i      (job_valid_i),
        .job_ready_o      (job_ready_o),
        .job_soda_i       (job_soda_i),
        .job_change_i     (job_change_i),
        .soda_motor_o     (soda_motor_o),
        .soda_done_i      (soda_done_i),
        .hopper_kick_o    (hopper_kick_o),
        .hopper_coin_i    (hopper_coin_i),
        .refill_valid_i   (refill_valid_i),
        .refill_nickels_i (refill_nickels_i),
        .fault_clear_i    (fault_clear_i),
        .nickel_count_o   (nickel_count_o),
        .low_change_o     (low_change_o),
        .busy_o           (busy_o),
        .fault_o          (fault_o),
        .fault_code_o     (fault_code_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       valid;
        logic       soda;
        logic [2:0] chg;
        logic       done;
        logic       coin;
        logic       refill;
        logic [5:0] rn;
        logic       e_ready;
        logic       e_motor;
        logic       e_kick;
        logic [5:0] e_count;
        logic       e_low;
        logic       e_busy;
    } vec_t;

    vec_t vecs [19];

    int tests = 0;
    int fails = 0;

    logic prev_motor = 1'b0;
    logic prev_kick  = 1'b0;
    bit   soda_pending = 1'b0;
    bit   coin_pending = 1'b0;
    bit   auto_soda = 1'b0;
    bit   auto_coin = 1'b0;
    int   motor_rises = 0;
    int   kick_rises = 0;
    int   job_idx = -1;
    int   job_kicks [8];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample just after the edge, log pulse edges, drive automatic acks.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (soda_motor_o && hopper_kick_o) begin
            check("drive_overlap", 1, 0);
        end
        if (soda_motor_o && !prev_motor) begin
            motor_rises++;
            if (job_idx < 7) job_idx++;
        end
        if (hopper_kick_o && !prev_kick) begin
            kick_rises++;
            if (job_idx >= 0) job_kicks[job_idx]++;
        end
        if (prev_motor && !soda_motor_o) soda_pending = 1'b1;
        if (prev_kick && !hopper_kick_o) coin_pending = 1'b1;
        prev_motor    = soda_motor_o;
        prev_kick     = hopper_kick_o;
        soda_done_i   = 1'b0;
        hopper_coin_i = 1'b0;
        if (auto_soda && soda_pending) begin
            soda_done_i  = 1'b1;
            soda_pending = 1'b0;
        end
        if (auto_coin && coin_pending) begin
            hopper_coin_i = 1'b1;
            coin_pending  = 1'b0;
        end
    endtask

    task automatic clear_log();
        motor_rises  = 0;
        kick_rises   = 0;
        job_idx      = -1;
        soda_pending = 1'b0;
        coin_pending = 1'b0;
        for (int i = 0; i < 8; i++) job_kicks[i] = 0;
    endtask

    task automatic apply_reset();
        job_valid_i    = 1'b0;
        refill_valid_i = 1'b0;
        fault_clear_i  = 1'b0;
        auto_soda      = 1'b0;
        auto_coin      = 1'b0;
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        clear_log();
    endtask

    task automatic refill(input int n);
        refill_valid_i   = 1'b1;
        refill_nickels_i = 6'(n);
        step();
        refill_valid_i   = 1'b0;
    endtask

    task automatic offer(input bit soda, input int chg);
        job_valid_i  = 1'b1;
        job_soda_i   = soda;
        job_change_i = 3'(chg);
    endtask

    task automatic run_until_idle(input int max_cycles, input string name);
        int n = 0;
        while (busy_o && n < max_cycles) begin
            step();
            n++;
        end
        check(name, int'(busy_o), 0);
    endtask

    function automatic vec_t mkv(input bit v, input bit s, input int c, input bit d,
                                 input bit k, input bit r, input int rn,
                                 input bit e_rdy, input bit e_m, input bit e_k,
                                 input int e_cnt, input bit e_low, input bit e_busy);
        vec_t m;
        m.valid   = v;
        m.soda    = s;
        m.chg     = 3'(c);
        m.done    = d;
        m.coin    = k;
        m.refill  = r;
        m.rn      = 6'(rn);
        m.e_ready = e_rdy;
        m.e_motor = e_m;
        m.e_kick  = e_k;
        m.e_count = 6'(e_cnt);
        m.e_low   = e_low;
        m.e_busy  = e_busy;
        return m;
    endfunction

    int chg5 [5];

    initial begin
        // Inputs applied before an edge -> outputs seen just after that edge.
        //              v  s  c  dn cn rf rn   rdy mot kik cnt low busy
        vecs[0]  = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b1,10, 1'b1,1'b0,1'b0,10,1'b0,1'b0); // refill 10
        vecs[1]  = mkv(1'b1,1'b1,2,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b0,10,1'b0,1'b1); // accepted -> POP
        vecs[2]  = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b1,1'b0,10,1'b0,1'b1); // motor on at t+2
        vecs[3]  = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b1,1'b0,10,1'b0,1'b1);
        vecs[4]  = mkv(1'b0,1'b0,0,1'b0,1'b1,1'b0,0,  1'b1,1'b1,1'b0,10,1'b0,1'b1); // stray coin ignored
        vecs[5]  = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b1,1'b0,10,1'b0,1'b1);
        vecs[6]  = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b0,10,1'b0,1'b1); // SODA_WAIT
        vecs[7]  = mkv(1'b0,1'b0,0,1'b1,1'b0,1'b0,0,  1'b1,1'b0,1'b1,10,1'b0,1'b1); // ack -> first kick
        vecs[8]  = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b1,10,1'b0,1'b1);
        vecs[9]  = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b1,10,1'b0,1'b1);
        vecs[10] = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b1,10,1'b0,1'b1);
        vecs[11] = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b0,10,1'b0,1'b1); // COIN_WAIT
        vecs[12] = mkv(1'b0,1'b0,0,1'b0,1'b1,1'b0,0,  1'b1,1'b0,1'b1,9, 1'b0,1'b1); // coin -> second kick
        vecs[13] = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b1,9, 1'b0,1'b1);
        vecs[14] = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b1,9, 1'b0,1'b1);
        vecs[15] = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b1,9, 1'b0,1'b1);
        vecs[16] = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b0,9, 1'b0,1'b1);
        vecs[17] = mkv(1'b0,1'b0,0,1'b0,1'b1,1'b0,0,  1'b1,1'b0,1'b0,8, 1'b0,1'b0); // last coin -> IDLE
        vecs[18] = mkv(1'b0,1'b0,0,1'b0,1'b0,1'b0,0,  1'b1,1'b0,1'b0,8, 1'b0,1'b0);

        // Reset state
        apply_reset();
        check("rst_ready", int'(job_ready_o), 1);
        check("rst_low", int'(low_change_o), 1);
        check("rst_count", int'(nickel_count_o), 0);
        check("rst_motor", int'(soda_motor_o), 0);
        check("rst_kick", int'(hopper_kick_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_fault", int'(fault_o), 0);
        check("rst_code", int'(fault_code_o), 0);

        // Soda + 2 nickels, cycle by cycle
        for (int i = 0; i < 19; i++) begin
            job_valid_i      = vecs[i].valid;
            job_soda_i       = vecs[i].soda;
            job_change_i     = vecs[i].chg;
            soda_done_i      = vecs[i].done;
            hopper_coin_i    = vecs[i].coin;
            refill_valid_i   = vecs[i].refill;
            refill_nickels_i = vecs[i].rn;
            step();
            check($sformatf("v%0d_ready", i), int'(job_ready_o), int'(vecs[i].e_ready));
            check($sformatf("v%0d_motor", i), int'(soda_motor_o), int'(vecs[i].e_motor));
            check($sformatf("v%0d_kick", i), int'(hopper_kick_o), int'(vecs[i].e_kick));
            check($sformatf("v%0d_count", i), int'(nickel_count_o), int'(vecs[i].e_count));
            check($sformatf("v%0d_low", i), int'(low_change_o), int'(vecs[i].e_low));
            check($sformatf("v%0d_busy", i), int'(busy_o), int'(vecs[i].e_busy));
            check($sformatf("v%0d_fault", i), int'(fault_o), 0);
        end
        job_valid_i    = 1'b0;
        refill_valid_i = 1'b0;

        // Five back-to-back jobs while the first stalls in SODA_WAIT (inventory 8)
        clear_log();
        auto_coin = 1'b1;
        chg5[0] = 0; chg5[1] = 1; chg5[2] = 0; chg5[3] = 2; chg5[4] = 1;
        for (int j = 0; j < 5; j++) begin
            offer(1'b1, chg5[j]);
            check($sformatf("q_ready_before_%0d", j), int'(job_ready_o), 1);
            step();
        end
        job_valid_i = 1'b0;
        check("q_full_ready", int'(job_ready_o), 0);
        step(); step(); step();
        check("q_still_full", int'(job_ready_o), 0);
        check("q_busy", int'(busy_o), 1);
        auto_soda = 1'b1;
        run_until_idle(3000, "q_drain_timeout");
        check("q_jobs_run", job_idx + 1, 5);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("q_kicks_job%0d", j), job_kicks[j], chg5[j]);
        end
        check("q_count", int'(nickel_count_o), 4);
        check("q_low_at_4", int'(low_change_o), 0);
        check("q_ready_back", int'(job_ready_o), 1);

        // Soda timeout with a job queued behind (inventory 4)
        clear_log();
        auto_soda = 1'b0;
        auto_coin = 1'b1;
        offer(1'b1, 1);
        step();
        offer(1'b0, 1);
        step();
        job_valid_i = 1'b0;
        check("to_motor_start", int'(soda_motor_o), 1);
        for (int k = 1; k < PULSE + TIMEOUT; k++) step();
        check("to_no_fault_early", int'(fault_o), 0);
        step();
        check("to_fault", int'(fault_o), 1);
        check("to_code", int'(fault_code_o), 1);
        check("to_motor_low", int'(soda_motor_o), 0);
        offer(1'b0, 0);
        check("to_ready_in_fault", int'(job_ready_o), 1);
        step();
        job_valid_i = 1'b0;
        step(); step();
        check("to_code_held", int'(fault_code_o), 1);
        check("to_fault_held", int'(fault_o), 1);
        check("to_count_held", int'(nickel_count_o), 4);
        fault_clear_i = 1'b1;
        step();
        fault_clear_i = 1'b0;
        check("to_cleared", int'(fault_o), 0);
        check("to_code_cleared", int'(fault_code_o), 0);
        run_until_idle(200, "to_drain_timeout");
        check("to_kicks", kick_rises, 1);
        check("to_count_after", int'(nickel_count_o), 3);
        check("to_low_at_3", int'(low_change_o), 1);

        // Unserviceable job: inventory 1, soda + 3 nickels
        apply_reset();
        refill(1);
        check("bad_count_1", int'(nickel_count_o), 1);
        offer(1'b1, 3);
        step();
        job_valid_i = 1'b0;
        step();
        check("bad_fault", int'(fault_o), 1);
        check("bad_code", int'(fault_code_o), 3);
        for (int k = 0; k < 5; k++) step();
        check("bad_no_motor", motor_rises, 0);
        check("bad_no_kick", kick_rises, 0);
        check("bad_count_kept", int'(nickel_count_o), 1);
        fault_clear_i = 1'b1;
        step();
        fault_clear_i = 1'b0;
        check("bad_cleared", int'(fault_o), 0);
        check("bad_idle", int'(busy_o), 0);

        // Saturation: refill and coin-out in the same cycle at 62
        refill(61);
        check("sat_count_62", int'(nickel_count_o), 62);
        offer(1'b0, 1);
        step();
        job_valid_i = 1'b0;
        step();
        check("sat_kick_on", int'(hopper_kick_o), 1);
        for (int k = 0; k < PULSE + 2 && hopper_kick_o; k++) step();
        check("sat_kick_off", int'(hopper_kick_o), 0);
        hopper_coin_i    = 1'b1;
        refill_valid_i   = 1'b1;
        refill_nickels_i = 6'd5;
        step();
        refill_valid_i   = 1'b0;
        check("sat_count_63", int'(nickel_count_o), 63);
        check("sat_idle", int'(busy_o), 0);
        refill(3);
        check("sat_stays_63", int'(nickel_count_o), 63);

        // Change above the per-vend limit is rejected even with full stock
        offer(1'b0, 5);
        step();
        job_valid_i = 1'b0;
        step();
        check("big_chg_code", int'(fault_code_o), 3);
        check("big_chg_kick", int'(hopper_kick_o), 0);
        fault_clear_i = 1'b1;
        step();
        fault_clear_i = 1'b0;

        // Reset during COIN_PULSE with another job queued
        apply_reset();
        refill(4);
        offer(1'b0, 2);
        step();
        offer(1'b1, 0);
        step();
        job_valid_i = 1'b0;
        check("mid_kick_on", int'(hopper_kick_o), 1);
        rst_i = 1'b1;
        step();
        check("mid_kick_drop", int'(hopper_kick_o), 0);
        check("mid_count", int'(nickel_count_o), 0);
        check("mid_ready", int'(job_ready_o), 1);
        check("mid_busy", int'(busy_o), 0);
        check("mid_low", int'(low_change_o), 1);
        rst_i = 1'b0;
        clear_log();
        for (int k = 0; k < 10; k++) step();
        check("mid_flushed_motor", motor_rises, 0);
        check("mid_flushed_kick", kick_rises, 0);
        check("mid_flushed_busy", int'(busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
